// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: data width, the transmitter state
//               encoding, and the baud rates the clock generator can
//               produce.
//               Optional feature macro: UART_TX_PARITY_EN adds the PARITY
//               state to the transmitter state set.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_W = 8;

    // Baud rates supported by the companion clock generator.
    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_edge.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_edge
// Description : Turns the divided baud clock into a single-cycle tick on
//               each rising edge of baud_clk, sampled in the clk domain.
// Ports       : clk         - system clock
//               rst         - synchronous active-high reset
//               baud_clk_i  - divided baud clock, synchronous to clk
//               baud_tick_o - one clk-wide pulse per baud period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_edge (
    input  logic clk,
    input  logic rst,
    input  logic baud_clk_i,
    output logic baud_tick_o
);

    logic baud_clk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_clk_q <= 1'b0;
        end else begin
            baud_clk_q <= baud_clk_i;
        end
    end

    // High on the first clk cycle in which baud_clk is seen high.
    assign baud_tick_o = baud_clk_i & ~baud_clk_q;

endmodule : uart_baud_edge
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Byte-wide UART transmitter. Sends start bit, 8 data bits
//               LSB first, optional even parity bit, then STOP_BITS stop
//               bits, each lasting exactly one baud period.
//               Optional feature macro: UART_TX_PARITY_EN inserts an even
//               parity bit between the last data bit and the stop bits.
// Parameters  : STOP_BITS - stop bits per frame (1 or 2)
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               baud_clk - divided baud clock, synchronous to clk
//               tx_valid - byte offered for transmission
//               tx_data  - byte to send
//               tx_ready - high while able to accept a byte
//               tx       - registered serial line, idles high
//               tx_busy  - high while a frame is in progress
//               tx_done  - one-cycle pulse at end of the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_clk,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    import uart_pkg::*;

    localparam int            CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_e       state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;
    logic              tx_q;
    logic              tx_ready_q;
    logic              tx_busy_q;
    logic              tx_done_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    logic baud_tick;
    logic accept;

    uart_baud_edge u_baud_edge (
        .clk         (clk),
        .rst         (rst),
        .baud_clk_i  (baud_clk),
        .baud_tick_o (baud_tick)
    );

    assign accept = tx_valid && tx_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Ready is held off for the tx_done cycle so that it
                    // rises the cycle after the done pulse.
                    if (tx_done_q) begin
                        tx_ready_q <= 1'b1;
                    end
                    if (accept) begin
                        shift_q    <= tx_data;
                        bit_cnt_q  <= '0;
                        tx_ready_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        state_q    <= ARM;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^tx_data;
`endif
                    end
                end
                ARM: begin
                    // Waiting for the next tick aligns the start bit to a
                    // full baud period; a tick in the accept cycle was seen
                    // in IDLE and so never reaches here.
                    if (baud_tick) begin
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            tx_done_q <= 1'b1;
                            tx_busy_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q       <= 1'b1;
                    tx_busy_q  <= 1'b0;
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Two instances share clock,
//               reset, baud clock and data: one with a single stop bit and
//               one with two. Captured serial waveforms are decoded slot by
//               slot and compared with frames built from the byte value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BAUD    = 20;
    localparam int CAP_MAX = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_clk = 1'b0;
    logic       baud_en  = 1'b1;
    int         bcnt     = 0;
    logic       tx_valid, tx_valid2;
    logic [7:0] tx_data;
    logic       tx, tx_ready, tx_busy, tx_done;
    logic       tx2, tx_ready2, tx_busy2, tx_done2;

    int checks = 0;
    int errors = 0;

    logic cap_tx [CAP_MAX];
    logic cap_done [CAP_MAX];
    logic cap_ready [CAP_MAX];
    logic cap_busy [CAP_MAX];
    int   cap_n;

    uart_tx #(.STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    uart_tx #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_valid(tx_valid2),
        .tx_data(tx_data), .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2),
        .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    // Baud clock: 20 clk period, 50% duty, holds its level while disabled.
    always @(negedge clk) begin
        if (baud_en) begin
            bcnt     = (bcnt == BAUD - 1) ? 0 : bcnt + 1;
            baud_clk = (bcnt < BAUD / 2);
        end
    end

    // Reference frame: bit i is the i-th bit on the line; unused tail is 1.
    function automatic logic [11:0] model_frame(input logic [7:0] d);
        logic [11:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (PAR == 1) f[9] = ^d;
        return f;
    endfunction

    // Offer a byte and return at the negedge before the accepting posedge.
    task automatic send_start(input bit sel, input logic [7:0] d);
        int guard;
        @(negedge clk);
        tx_data = d;
        if (sel) tx_valid2 = 1'b1; else tx_valid = 1'b1;
        guard = 0;
        while (((sel ? tx_ready2 : tx_ready) !== 1'b1) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Record one sample per clk starting the cycle after accept, until
    // ndone done pulses have been seen (plus a short tail).
    task automatic capture(input bit sel, input int ndone, input bit hold,
                           input logic [7:0] newd);
        int seen, tail;
        seen  = 0;
        tail  = 0;
        cap_n = 0;
        while (cap_n < CAP_MAX && tail < 3) begin
            @(negedge clk);
            cap_tx[cap_n]    = sel ? tx2 : tx;
            cap_done[cap_n]  = sel ? tx_done2 : tx_done;
            cap_ready[cap_n] = sel ? tx_ready2 : tx_ready;
            cap_busy[cap_n]  = sel ? tx_busy2 : tx_busy;
            if (cap_done[cap_n] === 1'b1) seen++;
            cap_n++;
            if (cap_n == 1) begin
                tx_data = newd;
                if (!hold) begin tx_valid = 1'b0; tx_valid2 = 1'b0; end
            end
            if (seen >= ndone) begin
                tail++;
                tx_valid  = 1'b0;
                tx_valid2 = 1'b0;
            end
        end
        checks++;
        if (seen < ndone) begin
            errors++;
            $display("FAIL capture_timeout done_pulses got %0d need %0d", seen, ndone);
        end
    endtask

    // Decode a captured frame: slot values at mid-slot, whether every slot
    // is flat for a full baud period, and where tx_done appears.
    task automatic analyze(input int from, input int sb, output logic [11:0] bits,
                           output bit stable, output int done_rel, output int done_abs);
        int s, n, k;
        bits = '1; stable = 1'b1; done_rel = -1; done_abs = -1; s = -1;
        n = 9 + PAR + sb;
        for (int i = from; i < cap_n; i++) if (cap_tx[i] === 1'b0) begin s = i; break; end
        if (s < 0) begin stable = 1'b0; return; end
        for (int b = 0; b < n; b++) begin
            k = s + BAUD * b + BAUD / 2;
            if (k < cap_n) bits[b] = cap_tx[k]; else stable = 1'b0;
            for (int j = 0; j < BAUD; j++) begin
                k = s + BAUD * b + j;
                if (k >= cap_n || cap_tx[k] !== bits[b]) stable = 1'b0;
            end
        end
        for (int i = s; i < cap_n; i++) if (cap_done[i] === 1'b1) begin
            done_abs = i; done_rel = i - s; break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", tx_done); end
        checks++; if (tx2 !== 1'b1)     begin errors++; $display("FAIL reset_tx2 got %b exp 1", tx2); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", tx_ready); end
        checks++; if (tx_ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready2 got %b exp 1", tx_ready2); end
    endtask

    task automatic test_frames(input int nrand);
        logic [11:0] bits;
        bit          stable;
        int          drel, dabs, npulse;
        logic [7:0]  d;
        for (int t = 0; t < nrand + 3; t++) begin
            d = (t == 0) ? 8'hA5 : (t == 1) ? 8'h07 : (t == 2) ? 8'h03 : 8'($urandom);
            send_start(1'b0, d);
            capture(1'b0, 1, 1'b0, 8'($urandom));
            analyze(0, 1, bits, stable, drel, dabs);
            npulse = 0;
            for (int i = 0; i < cap_n; i++) if (cap_done[i] === 1'b1) npulse++;
            checks++; if (bits !== model_frame(d)) begin errors++; $display("FAIL frame_bits byte %h got %h exp %h", d, bits, model_frame(d)); end
            checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bit_period byte %h got unstable exp %0d clk per bit", d, BAUD); end
            checks++; if (drel !== BAUD * (10 + PAR)) begin errors++; $display("FAIL done_time byte %h got %0d exp %0d", d, drel, BAUD * (10 + PAR)); end
            checks++; if (npulse !== 1) begin errors++; $display("FAIL done_pulses byte %h got %0d exp 1", d, npulse); end
            if (dabs > 0 && dabs + 1 < cap_n) begin
                checks++; if (cap_busy[dabs-1] !== 1'b1 || cap_busy[dabs] !== 1'b0) begin
                    errors++; $display("FAIL busy_edge byte %h got %b%b exp 10", d, cap_busy[dabs-1], cap_busy[dabs]); end
                checks++; if (cap_ready[dabs] !== 1'b0 || cap_ready[dabs+1] !== 1'b1) begin
                    errors++; $display("FAIL ready_after_done byte %h got %b%b exp 01", d, cap_ready[dabs], cap_ready[dabs+1]); end
            end
`ifdef UART_TX_PARITY_EN
            if (t == 1) begin checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL parity_07 got %b exp 1", bits[9]); end end
            if (t == 2) begin checks++; if (bits[9] !== 1'b0) begin errors++; $display("FAIL parity_03 got %b exp 0", bits[9]); end end
`endif
        end
    endtask

    task automatic test_busy_drop();
        logic [11:0] bits;
        bit          stable;
        int          drel, dabs, nready;
        send_start(1'b0, 8'h55);
        capture(1'b0, 1, 1'b1, 8'hFF);
        analyze(0, 1, bits, stable, drel, dabs);
        nready = 0;
        for (int i = 0; i <= dabs && i < cap_n; i++) if (cap_ready[i] !== 1'b0) nready++;
        checks++; if (bits !== model_frame(8'h55)) begin errors++; $display("FAIL busy_drop_bits got %h exp %h", bits, model_frame(8'h55)); end
        checks++; if (nready !== 0 || dabs < 0) begin errors++; $display("FAIL busy_drop_ready got %0d ready cycles exp 0", nready); end
        repeat (5) @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL busy_drop_extra got busy %b exp 0", tx_busy); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] b1, b2;
        bit          s1, s2;
        int          dr1, da1, dr2, da2, nready;
        send_start(1'b0, 8'h01);
        capture(1'b0, 2, 1'b1, 8'h80);
        analyze(0, 1, b1, s1, dr1, da1);
        analyze(da1 + 1, 1, b2, s2, dr2, da2);
        nready = 0;
        for (int i = da1; i < da2 && i >= 0; i++) if (cap_ready[i] === 1'b1) nready++;
        checks++; if (b1 !== model_frame(8'h01) || s1 !== 1'b1) begin errors++; $display("FAIL b2b_frame1 got %h exp %h", b1, model_frame(8'h01)); end
        checks++; if (b2 !== model_frame(8'h80) || s2 !== 1'b1) begin errors++; $display("FAIL b2b_frame2 got %h exp %h", b2, model_frame(8'h80)); end
        checks++; if (nready !== 1 || da2 < 0) begin errors++; $display("FAIL b2b_ready_gap got %0d cycles exp 1", nready); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] bits;
        bit          stable;
        int          drel, dabs, guard, npulse;
        send_start(1'b0, 8'hF0);
        @(negedge clk);
        tx_valid = 1'b0;
        guard = 0;
        while (tx !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        repeat (BAUD * 4 + 5) @(negedge clk);
        checks++; if (tx_busy !== 1'b1 || tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got tx %b busy %b exp 0 1", tx, tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset got tx %b busy %b done %b exp 1 0 0", tx, tx_busy, tx_done); end
        rst = 1'b0;
        npulse = 0;
        repeat (300) begin @(negedge clk); if (tx_done === 1'b1) npulse++; end
        checks++; if (npulse !== 0) begin errors++; $display("FAIL mid_no_done got %0d pulses exp 0", npulse); end
        send_start(1'b0, 8'h3C);
        capture(1'b0, 1, 1'b0, 8'($urandom));
        analyze(0, 1, bits, stable, drel, dabs);
        checks++; if (bits !== model_frame(8'h3C) || stable !== 1'b1) begin errors++; $display("FAIL after_reset_3C got %h exp %h", bits, model_frame(8'h3C)); end
    endtask

    task automatic test_freeze();
        int guard, changes;
        logic first;
        send_start(1'b0, 8'($urandom));
        @(negedge clk);
        tx_valid = 1'b0;
        guard = 0;
        while (tx !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        repeat (BAUD + 7) @(negedge clk);
        baud_en = 1'b0;
        @(negedge clk);
        first = tx;
        changes = 0;
        repeat (60) begin @(negedge clk); if (tx !== first || tx_busy !== 1'b1 || tx_done !== 1'b0) changes++; end
        checks++; if (changes !== 0) begin errors++; $display("FAIL freeze_hold got %0d changed cycles exp 0", changes); end
        baud_en = 1'b1;
        guard = 0;
        while (tx_done !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL freeze_resume got done %b exp 1", tx_done); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stop2();
        logic [11:0] bits;
        bit          stable;
        int          drel, dabs, nhigh;
        send_start(1'b1, 8'h00);
        capture(1'b1, 1, 1'b0, 8'($urandom));
        analyze(0, 2, bits, stable, drel, dabs);
        nhigh = 0;
        for (int i = dabs - 1; i >= 0 && cap_tx[i] === 1'b1; i--) nhigh++;
        checks++; if (bits !== model_frame(8'h00) || stable !== 1'b1) begin errors++; $display("FAIL stop2_bits got %h exp %h", bits, model_frame(8'h00)); end
        checks++; if (nhigh !== 2 * BAUD || dabs < 0) begin errors++; $display("FAIL stop2_high got %0d clk exp %0d", nhigh, 2 * BAUD); end
        checks++; if (drel !== BAUD * (11 + PAR)) begin errors++; $display("FAIL stop2_done_time got %0d exp %0d", drel, BAUD * (11 + PAR)); end
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        tx_data   = 8'h00;
        test_reset();
        test_frames(4);
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        test_freeze();
        test_stop2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port baud_clk  input  1  divided baud clock from the clock generator, synchronous to clk, 50% duty.
REQ-005 SHALL have port tx_valid  input  1  byte offered for transmission.
REQ-006 SHALL have port tx_data  input  8  byte to send, LSB first.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE; accept on tx_valid&&tx_ready.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port tx_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port tx_done  output  1  one-clk pulse at end of last stop bit.

Function
REQ-011 SHALL derive baud_tick = baud_clk & ~baud_clk_q, where baud_clk_q is baud_clk delayed one clk; one tick per baud period.
REQ-012 SHALL implement states IDLE, ARM, START, DATA, PARITY, STOP.
REQ-013 IDLE: on accept, latch tx_data into shift register, clear bit counter, go to ARM next cycle; tx stays 1.
REQ-014 ARM: on baud_tick, tx<=0, go to START; a tick coincident with the accept cycle SHALL be ignored.
REQ-015 START: on baud_tick, tx<=shift[0], go to DATA, bit counter=0.
REQ-016 DATA: on each baud_tick, shift right and increment counter; after bit 7 has been held one full tick, go to PARITY (if enabled) else STOP with tx<=1.
REQ-017 STOP: tx=1 for STOP_BITS baud ticks; on the final tick go to IDLE and assert tx_done for exactly one clk.
REQ-018 Every bit SHALL last exactly one baud period (tick to tick), ±0 clk.
REQ-019 tx_valid while tx_ready=0 SHALL be ignored; tx_data changes after accept SHALL not affect the frame in flight.
REQ-020 Back-to-back: tx_ready SHALL rise the cycle after tx_done; a new accept then starts a new ARM.
REQ-021 baud_clk stopped mid-frame SHALL freeze state and tx without error.

Reset
REQ-022 On rst: state=IDLE, tx=1, tx_ready=1 after reset release, tx_busy=0, tx_done=0, shift register and counters=0, baud_clk_q=0.
REQ-023 rst asserted mid-frame SHALL abort the frame; tx SHALL be 1 on the cycle after the rst edge.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, driving even parity (XOR of the 8 data bits) for one baud period; frame = 1+8+1+STOP_BITS bits.
REQ-025 UART_TX_PARITY_EN undefined: PARITY state and parity logic absent; DATA goes straight to STOP; frame = 1+8+STOP_BITS bits.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type, DATA_W=8, and the supported baud-rate constants shared with the clock generator.
REQ-027 Sub-module uart_baud_edge SHALL contain the baud_clk register and tick derivation; uart_tx instantiates it once.

Verification
REQ-028 Single byte: baud_clk period 20 clk, send 8'hA5, parity off, STOP_BITS=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 20 clk; one tx_done pulse.
REQ-029 Parity: UART_TX_PARITY_EN, send 8'h07 -> parity bit 1 after bit 7; send 8'h03 -> parity bit 0.
REQ-030 Busy-drop: offer 8'h55 then 8'hFF during the frame -> only 8'h55 sent; tx_ready=0 throughout the frame.
REQ-031 Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> two complete frames, tx_ready high for exactly one cycle between them.
REQ-032 Reset mid-frame: rst at DATA bit 3 -> tx=1 next cycle, tx_busy=0, no tx_done; next byte 8'h3C transmitted correctly.
REQ-033 STOP_BITS=2: send 8'h00 -> tx high for 40 clk after bit 7 before tx_done.
